// File: rtl/i2s_tx_slave.sv
// rtl/i2s_tx_slave.sv - I2S transmitter slaved to an external bclk/lrclk master
module i2s_tx_slave #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bclk,
   input  logic              lrclk,
   input  logic [DATA_W-1:0] l_sample,
   input  logic [DATA_W-1:0] r_sample,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              sdata,
   output logic              underrun
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;
   state_t state, state_next;

   logic              bclk_s1, bclk_s2, bclk_d;
   logic              lrclk_s1, lrclk_s2;
   logic              lr_prev, lr_seen;
   logic              fall, chg, left_chg, accept, full_next, word_done;
   logic              chan;
   logic              hold_full;
   logic [DATA_W-1:0] hold_l, hold_r, active_l, active_r, word;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
   logic              sdata_next;

   // A fall is seen on the synchronized bclk only. lr_seen keeps the
   // very first fall after reset from counting as a channel change.
   assign fall      = bclk_d & ~bclk_s2;
   assign chg       = fall & lr_seen & (lrclk_s2 != lr_prev);
   assign left_chg  = chg & ~lrclk_s2;
   assign accept    = sample_valid & sample_ready;
   assign full_next = accept | (hold_full & ~left_chg);
   assign word      = chan ? active_r : active_l;
   assign word_done = (bit_cnt == CNT_W'(DATA_W));

   // Synchronize bclk/lrclk and remember lrclk as seen at the last fall
   always_ff @(posedge clk) begin
      if (!reset) begin
         bclk_s1  <= 1'b0;
         bclk_s2  <= 1'b0;
         bclk_d   <= 1'b0;
         lrclk_s1 <= 1'b0;
         lrclk_s2 <= 1'b0;
         lr_prev  <= 1'b0;
         lr_seen  <= 1'b0;
         chan     <= 1'b0;
      end else begin
         bclk_s1  <= bclk;
         bclk_s2  <= bclk_s1;
         bclk_d   <= bclk_s2;
         lrclk_s1 <= lrclk;
         lrclk_s2 <= lrclk_s1;
         if (fall) begin
            lr_prev <= lrclk_s2;
            lr_seen <= 1'b1;
         end
         if (chg)
            chan <= lrclk_s2;
      end
   end

   // Holding register handshake and frame-start transfer to the active words.
   // A left change reads the old holding contents, so a pair accepted on the
   // same clk simply becomes the next frame's pair.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_l       <= '0;
         hold_r       <= '0;
         active_l     <= '0;
         active_r     <= '0;
         hold_full    <= 1'b0;
         sample_ready <= 1'b1;
         underrun     <= 1'b0;
      end else begin
         underrun <= left_chg & ~hold_full;
         if (left_chg) begin
            if (hold_full) begin
               active_l <= hold_l;
               active_r <= hold_r;
            end else begin
               active_l <= '0;
               active_r <= '0;
            end
         end
         if (accept) begin
            hold_l <= l_sample;
            hold_r <= r_sample;
         end
         hold_full    <= full_next;
         sample_ready <= ~full_next;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // FSM next-state: every slot starts with a one-bclk delay after the change
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:  if (chg) state_next = DELAY;
         DELAY: if (fall && !chg) state_next = SHIFT;
         SHIFT: begin
            if (fall) begin
               if (chg)
                  state_next = DELAY;
               else if (word_done)
                  state_next = PAD;
            end
         end
         PAD:   if (chg) state_next = DELAY;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: next serial bit, shift register and bit counter
   always_comb begin
      sdata_next   = sdata;
      shreg_next   = shreg;
      bit_cnt_next = bit_cnt;
      unique case (state)
         IDLE: sdata_next = 1'b0;
         DELAY: begin
            sdata_next = 1'b0;
            if (fall && !chg) begin
               sdata_next   = word[DATA_W-1];
               shreg_next   = word << 1;
               bit_cnt_next = CNT_W'(1);
            end
         end
         SHIFT: begin
            if (fall) begin
               if (chg || word_done) begin
                  sdata_next   = 1'b0;
                  bit_cnt_next = '0;
               end else begin
                  sdata_next   = shreg[DATA_W-1];
                  shreg_next   = shreg << 1;
                  bit_cnt_next = bit_cnt + CNT_W'(1);
               end
            end
         end
         PAD: sdata_next = 1'b0;
         default: sdata_next = 1'b0;
      endcase
   end

   // Serializer registers; reset aborts any word in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         sdata   <= 1'b0;
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         sdata   <= sdata_next;
         shreg   <= shreg_next;
         bit_cnt <= bit_cnt_next;
      end
   end

endmodule

// File: tb/tb_i2s_tx_slave.sv
// tb/tb_i2s_tx_slave.sv - directed bench for i2s_tx_slave
module tb_i2s_tx_slave;
   logic        clk = 1'b0;
   logic        reset;
   logic        bclk;
   logic        lrclk;
   logic [15:0] l_sample;
   logic [15:0] r_sample;
   logic        sample_valid;
   logic        sample_ready;
   logic        sdata;
   logic        underrun;

   int errors = 0;
   int checks = 0;
   int ucnt   = 0;
   logic [63:0] v;

   i2s_tx_slave #(.DATA_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .l_sample     (l_sample),
      .r_sample     (r_sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sdata        (sdata),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   // count clk cycles with underrun high, sampled away from the active edge
   always @(negedge clk) begin
      if (underrun) ucnt++;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [15:0] pl, input logic [15:0] pr);
      @(negedge clk);
      l_sample     = pl;
      r_sample     = pr;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // n bclk periods with lrclk=lr; bit i is sampled late in the bclk-high
   // phase and shifted in MSB-first. Optionally offers a pair starting on the
   // clk where the DUT sees the first fall, for plen clks.
   task automatic slot(input logic lr, input int n, input int plen,
                       input logic [15:0] pl, input logic [15:0] pr,
                       output logic [63:0] bits);
      bits = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bclk  = 1'b0;
         lrclk = lr;
         for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (plen > 0 && i == 0 && j == 2) begin
               l_sample     = pl;
               r_sample     = pr;
               sample_valid = 1'b1;
            end
            if (plen > 0 && i == 0 && j == 2 + plen)
               sample_valid = 1'b0;
         end
         bclk = 1'b1;
         repeat (7) @(negedge clk);
         bits = {bits[62:0], sdata};
      end
   endtask

   initial begin
      reset        = 1'b0;
      bclk         = 1'b1;
      lrclk        = 1'b1;
      l_sample     = '0;
      r_sample     = '0;
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("rst_sdata", sdata, 0);
      check_eq("rst_ready", sample_ready, 1);
      check_eq("rst_underrun", underrun, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // basic frame, 32 bclk per slot
      push(16'hA5C3, 16'h0001);
      check_eq("t1_ready_full", sample_ready, 0);
      slot(1'b1, 4, 0, 16'h0, 16'h0, v);
      check_eq("t1_idle", v, 0);
      slot(1'b0, 32, 0, 16'h0, 16'h0, v);
      check_eq("t1_left", v[31:0], 32'h52E18000);
      check_eq("t1_ready_rise", sample_ready, 1);
      check_eq("t1_no_underrun", ucnt, 0);
      slot(1'b1, 32, 0, 16'h0, 16'h0, v);
      check_eq("t1_right", v[31:0], 32'h00008000);

      // underrun frame
      slot(1'b0, 32, 0, 16'h0, 16'h0, v);
      check_eq("t2_left_zero", v[31:0], 0);
      check_eq("t2_underrun_once", ucnt, 1);
      slot(1'b1, 32, 0, 16'h0, 16'h0, v);
      check_eq("t2_right_zero", v[31:0], 0);

      // P1 queued, P2 offered from the left-change clk onward
      push(16'h1234, 16'h5678);
      slot(1'b0, 32, 2, 16'h9ABC, 16'hDEF0, v);
      check_eq("t3_left_p1", v[31:0], {1'b0, 16'h1234, 15'h0});
      check_eq("t3_p2_held", sample_ready, 0);
      slot(1'b1, 32, 0, 16'h0, 16'h0, v);
      check_eq("t3_right_p1", v[31:0], {1'b0, 16'h5678, 15'h0});
      slot(1'b0, 32, 0, 16'h0, 16'h0, v);
      check_eq("t3_left_p2", v[31:0], {1'b0, 16'h9ABC, 15'h0});
      check_eq("t3_ready_after", sample_ready, 1);
      slot(1'b1, 32, 0, 16'h0, 16'h0, v);
      check_eq("t3_right_p2", v[31:0], {1'b0, 16'hDEF0, 15'h0});
      check_eq("t3_no_underrun", ucnt, 1);

      // 16 bclk slots: LSB truncated
      push(16'hC001, 16'h8003);
      slot(1'b0, 16, 0, 16'h0, 16'h0, v);
      check_eq("t4_left_trunc", v[15:0], 16'h6000);
      slot(1'b1, 16, 0, 16'h0, 16'h0, v);
      check_eq("t4_right_trunc", v[15:0], 16'h4001);
      // empty at left change with a write on the same clk
      slot(1'b0, 16, 1, 16'hFFFF, 16'hFFFF, v);
      check_eq("t4_underrun_zero", v[15:0], 0);
      check_eq("t4_underrun_cnt", ucnt, 2);
      check_eq("t4_pair_held", sample_ready, 0);
      slot(1'b1, 16, 0, 16'h0, 16'h0, v);
      check_eq("t4_right_zero", v[15:0], 0);

      // reset during bit 7 of a left word
      slot(1'b0, 8, 0, 16'h0, 16'h0, v);
      check_eq("t5_left_head", v[7:0], 8'h7F);
      check_eq("t5_sdata_before", sdata, 1);
      reset = 1'b0;
      @(negedge clk);
      check_eq("t5_sdata_reset", sdata, 0);
      check_eq("t5_ready_reset", sample_ready, 1);
      @(negedge clk);
      reset = 1'b1;
      slot(1'b0, 8, 0, 16'h0, 16'h0, v);
      check_eq("t5_quiet", v[7:0], 0);
      push(16'h1111, 16'h2222);
      slot(1'b1, 32, 0, 16'h0, 16'h0, v);
      check_eq("t5_right_cleared", v[31:0], 0);
      slot(1'b0, 32, 0, 16'h0, 16'h0, v);
      check_eq("t5_left_resume", v[31:0], {1'b0, 16'h1111, 15'h0});
      slot(1'b1, 32, 0, 16'h0, 16'h0, v);
      check_eq("t5_right_resume", v[31:0], {1'b0, 16'h2222, 15'h0});
      check_eq("t5_underrun_cnt", ucnt, 2);

      // valid held while not ready must be ignored
      push(16'h4321, 16'h8765);
      check_eq("t6_ready_low", sample_ready, 0);
      sample_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         l_sample = 16'h0F00 + 16'(k);
         r_sample = 16'hF000 + 16'(k);
         @(negedge clk);
      end
      sample_valid = 1'b0;
      check_eq("t6_ready_still_low", sample_ready, 0);
      slot(1'b0, 32, 0, 16'h0, 16'h0, v);
      check_eq("t6_left", v[31:0], {1'b0, 16'h4321, 15'h0});
      slot(1'b1, 32, 0, 16'h0, 16'h0, v);
      check_eq("t6_right", v[31:0], {1'b0, 16'h8765, 15'h0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
